// File: rtl/dino_pkg.sv
// Shared dino game types and playfield constants, used by the obstacle
// scheduler and the sprite-layer renderer.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    CACTUS1 = 2'd0,
    CACTUS2 = 2'd1,
    CACTUS3 = 2'd2
  } obst_type_t;

  localparam int SCREEN_W = 640;
  localparam int OBST_W   = 27;
  localparam int GAP_W    = 10;

  // Only three sprites exist, so the spare random code folds onto the first.
  function automatic obst_type_t rand_to_type(input logic [1:0] r);
    return (r == 2'd3) ? CACTUS1 : obst_type_t'(r);
  endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Registered obstacle slot state published by the scheduler (master) and
// read by the sprite-layer renderer (slave).
interface obstacle_scheduler_if #(
  parameter int NUM_SLOTS = 3,
  parameter int X_W       = 11
);
  logic [NUM_SLOTS-1:0]     slot_active;
  logic [2*NUM_SLOTS-1:0]   slot_type;
  logic [X_W*NUM_SLOTS-1:0] slot_x;
  logic [3:0]               speed;
  logic                     spawn_pulse;
  logic                     running;

  modport master (
    output slot_active, slot_type, slot_x, speed, spawn_pulse, running
  );

  modport slave (
    input slot_active, slot_type, slot_x, speed, spawn_pulse, running
  );
endinterface

// File: rtl/obstacle_scheduler_slot.sv
// One obstacle slot: holds active/type/right-edge x and scrolls it left on
// each applied frame tick, flagging when it is about to leave the screen.
module obstacle_slot
  import dino_pkg::*;
#(
  parameter int             X_W    = 11,
  parameter logic [X_W-1:0] LOAD_X = X_W'(SCREEN_W + OBST_W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [3:0]     speed,
  input  logic           load,
  input  obst_type_t     load_type,
  input  logic           clear,
  output logic           active,
  output obst_type_t     obst_type,
  output logic [X_W-1:0] x,
  output logic           retiring
);

  logic [X_W-1:0] step;

  assign step     = {{(X_W-4){1'b0}}, speed};
  assign retiring = active && (x <= step);

  // A retiring slot may be reloaded on the same tick, so load outranks move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      obst_type <= CACTUS1;
      x         <= '0;
    end else if (clear) begin
      active    <= 1'b0;
      obst_type <= CACTUS1;
      x         <= '0;
    end else if (load) begin
      active    <= 1'b1;
      obst_type <= load_type;
      x         <= LOAD_X;
    end else if (tick && active) begin
      if (retiring) begin
        active <= 1'b0;
      end else begin
        x <= x - step;
      end
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Frame-synchronous obstacle scheduler: FSM, spawn gap counter, free-slot
// priority encoder and scroll speed. Define SCHED_SPEEDUP_EN for speed-up.
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int NUM_SLOTS = 3,
  parameter int X_W       = 11,
  parameter int OBST_W    = dino_pkg::OBST_W,
  parameter int SCREEN_W  = dino_pkg::SCREEN_W,
  parameter int GAP_MIN   = 200,
  parameter int BASE_STEP = 2,
  parameter int MAX_STEP  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 halt,
  input  logic                 restart,
  input  logic [7:0]           rand_val,
  obstacle_scheduler_if.master sched
);

  localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_W + OBST_W);

  if (NUM_SLOTS < 2 || NUM_SLOTS > 4 || MAX_STEP > 15 || BASE_STEP > MAX_STEP
      || GAP_MIN + 252 > 1023) begin : g_bad_cfg
    $error("obstacle_scheduler: unsupported parameter combination");
  end

  sched_state_t         state, state_next;
  logic                 tick_apply;
  logic                 spawn;
  logic                 spawn_pulse;
  logic [GAP_W-1:0]     gap_cnt, gap_dec;
  logic [3:0]           speed;
  logic [NUM_SLOTS-1:0] active, retiring, free, load;
  obst_type_t           spawn_type;
  obst_type_t           types [NUM_SLOTS];
  logic [X_W-1:0]       xs    [NUM_SLOTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Restart beats halt and frame_tick; a tick coinciding with halt is dropped.
  always_comb begin
    state_next = state;
    tick_apply = 1'b0;
    unique case (state)
      IDLE:    if (restart) state_next = RUN;
      RUN: begin
        if (restart) begin
          state_next = RUN;
        end else if (halt) begin
          state_next = FROZEN;
        end else begin
          tick_apply = frame_tick;
        end
      end
      FROZEN:  if (restart) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gap_dec = (gap_cnt > GAP_W'(speed)) ? gap_cnt - GAP_W'(speed) : '0;
    free    = ~active | retiring;
    load    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) begin
        load    = '0;
        load[i] = 1'b1;
      end
    end
    spawn = tick_apply && (gap_dec == '0) && (|free);
    if (!spawn) load = '0;
  end

  assign spawn_type = rand_to_type(rand_val[1:0]);

  // With no free slot the counter simply sits at zero until one frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt     <= GAP_W'(GAP_MIN);
      spawn_pulse <= 1'b0;
    end else begin
      spawn_pulse <= spawn;
      if (restart) begin
        gap_cnt <= GAP_W'(GAP_MIN);
      end else if (spawn) begin
        gap_cnt <= GAP_W'(GAP_MIN) + {2'b00, rand_val[7:2], 2'b00};
      end else if (tick_apply) begin
        gap_cnt <= gap_dec;
      end
    end
  end

`ifdef SCHED_SPEEDUP_EN
  logic [3:0] spawn_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn_cnt <= '0;
      speed     <= 4'(BASE_STEP);
    end else if (restart) begin
      spawn_cnt <= '0;
      speed     <= 4'(BASE_STEP);
    end else if (spawn) begin
      spawn_cnt <= spawn_cnt + 4'd1;
      if (spawn_cnt == 4'hF && speed < 4'(MAX_STEP)) begin
        speed <= speed + 4'd1;
      end
    end
  end
`else
  assign speed = 4'(BASE_STEP);
`endif

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    obstacle_slot #(
      .X_W    (X_W),
      .LOAD_X (SPAWN_X)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick_apply),
      .speed     (speed),
      .load      (load[i]),
      .load_type (spawn_type),
      .clear     (restart),
      .active    (active[i]),
      .obst_type (types[i]),
      .x         (xs[i]),
      .retiring  (retiring[i])
    );

    assign sched.slot_type[2*i +: 2]  = types[i];
    assign sched.slot_x[X_W*i +: X_W] = xs[i];
  end

  assign sched.slot_active = active;
  assign sched.speed       = speed;
  assign sched.spawn_pulse = spawn_pulse;
  assign sched.running     = (state == RUN);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: a vector table for the main flow plus
// hand-written sequences for deferral, retire/reuse, restart and reset corners.
module tb_obstacle_scheduler;
  import dino_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       halt = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] rand_val = 8'h00;

  int vec_count  = 0;
  int fail_count = 0;
  int pulses     = 0;
  int pulses_g   = 0;
  int stray      = 0;

  always #5 clk = ~clk;

  obstacle_scheduler_if #(.NUM_SLOTS(3), .X_W(11)) sif ();
  obstacle_scheduler_if #(.NUM_SLOTS(3), .X_W(11)) gif ();

  obstacle_scheduler #(.NUM_SLOTS(3), .X_W(11), .GAP_MIN(200)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .halt(halt),
    .restart(restart), .rand_val(rand_val), .sched(sif.master)
  );

  obstacle_scheduler #(.NUM_SLOTS(3), .X_W(11), .GAP_MIN(4)) dut_g (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .halt(halt),
    .restart(restart), .rand_val(rand_val), .sched(gif.master)
  );

  typedef struct {
    string      name;
    bit         do_restart;
    bit         halt_v;
    int         n_ticks;
    logic [7:0] rand_v;
    logic [2:0] exp_active;
    int         exp_x0;
    int         exp_t0;
    bit         exp_running;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [10];

  function automatic int xof(input logic [32:0] v, input int i);
    return int'(v[11*i +: 11]);
  endfunction

  function automatic int tof(input logic [5:0] v, input int i);
    return int'(v[2*i +: 2]);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One frame tick followed by one quiet cycle; pulses are sampled between.
  task automatic doTick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    pulses   += int'(sif.spawn_pulse);
    pulses_g += int'(gif.spawn_pulse);
    @(negedge clk);
    if (sif.spawn_pulse) stray++;
  endtask

  task automatic doRestart(input logic [7:0] r);
    @(negedge clk);
    halt     = 1'b0;
    rand_val = r;
    restart  = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    halt     = v.halt_v;
    rand_val = v.rand_v;
    restart  = v.do_restart;
    @(negedge clk);
    restart  = 1'b0;
    pulses   = 0;
    for (int n = 0; n < v.n_ticks; n++) doTick();
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"reset",          1'b0, 1'b0,  0, 8'h00, 3'b000,   0, 0, 1'b0, 0};
    vecs[1] = '{"idle_ticks",     1'b0, 1'b0,  5, 8'h00, 3'b000,   0, 0, 1'b0, 0};
    vecs[2] = '{"restart",        1'b1, 1'b0,  0, 8'h00, 3'b000,   0, 0, 1'b1, 0};
    vecs[3] = '{"pre_spawn",      1'b0, 1'b0, 99, 8'h00, 3'b000,   0, 0, 1'b1, 0};
    vecs[4] = '{"first_spawn",    1'b0, 1'b0,  1, 8'h00, 3'b001, 667, 0, 1'b1, 1};
    vecs[5] = '{"scroll10",       1'b0, 1'b0, 10, 8'hFF, 3'b001, 647, 0, 1'b1, 0};
    vecs[6] = '{"halt_freeze",    1'b0, 1'b1, 10, 8'hFF, 3'b001, 647, 0, 1'b0, 0};
    vecs[7] = '{"restart_halted", 1'b1, 1'b1,  0, 8'h00, 3'b000,   0, 0, 1'b1, 0};
    vecs[8] = '{"frozen_again",   1'b0, 1'b1,  3, 8'h00, 3'b000,   0, 0, 1'b0, 0};
    vecs[9] = '{"restart_clean",  1'b1, 1'b0,  0, 8'h00, 3'b000,   0, 0, 1'b1, 0};

    #12;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput({vecs[k].name, ".active"},  int'(sif.slot_active), int'(vecs[k].exp_active));
      checkOutput({vecs[k].name, ".x0"},      xof(sif.slot_x, 0),    vecs[k].exp_x0);
      checkOutput({vecs[k].name, ".type0"},   tof(sif.slot_type, 0), vecs[k].exp_t0);
      checkOutput({vecs[k].name, ".running"}, int'(sif.running),     int'(vecs[k].exp_running));
      checkOutput({vecs[k].name, ".pulses"},  pulses,                vecs[k].exp_pulses);
      checkOutput({vecs[k].name, ".speed"},   int'(sif.speed),       2);
    end
    checkOutput("pulse_single_cycle", stray, 0);

    // restart coinciding with frame_tick: cleared, no movement, gap reloaded
    doRestart(8'h00);
    for (int n = 0; n < 100; n++) doTick();
    checkOutput("coinc.pre_active", int'(sif.slot_active), 1);
    @(negedge clk);
    restart = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    frame_tick = 1'b0;
    checkOutput("coinc.active", int'(sif.slot_active), 0);
    checkOutput("coinc.x0", xof(sif.slot_x, 0), 0);
    checkOutput("coinc.running", int'(sif.running), 1);
    pulses = 0;
    for (int n = 0; n < 99; n++) doTick();
    checkOutput("coinc.no_early_spawn", pulses, 0);
    doTick();
    checkOutput("coinc.spawn_at_100", pulses, 1);
    checkOutput("coinc.spawn_x0", xof(sif.slot_x, 0), 667);

    // asynchronous reset while a spawn pulse and a live slot are showing
    doRestart(8'h00);
    for (int n = 0; n < 99; n++) doTick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checkOutput("areset.pre_pulse", int'(sif.spawn_pulse), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset.active", int'(sif.slot_active), 0);
    checkOutput("areset.x", int'(sif.slot_x), 0);
    checkOutput("areset.type", int'(sif.slot_type), 0);
    checkOutput("areset.pulse", int'(sif.spawn_pulse), 0);
    checkOutput("areset.running", int'(sif.running), 0);
    checkOutput("areset.speed", int'(sif.speed), 2);
    @(negedge clk);
    rst_n = 1'b1;
    doTick();
    checkOutput("areset.idle_after", int'(sif.running), 0);

    // steady run with rand=FF: spacing, retire boundary, slot reuse
    doRestart(8'hFF);
    pulses = 0;
    for (int n = 0; n < 100; n++) doTick();
    checkOutput("ff.first_pulse", pulses, 1);
    checkOutput("ff.first_type", tof(sif.slot_type, 0), 0);
    pulses = 0;
    for (int k = 1; k <= 452; k++) begin
      doTick();
      case (k)
        5:   checkOutput("ff.x0_k5", xof(sif.slot_x, 0), 657);
        225: checkOutput("ff.no_pulse_k225", pulses, 0);
        226: begin
          checkOutput("ff.pulse_k226", pulses, 1);
          checkOutput("ff.active_k226", int'(sif.slot_active), 3);
          checkOutput("ff.x1_k226", xof(sif.slot_x, 1), 667);
          checkOutput("ff.type1_k226", tof(sif.slot_type, 1), 0);
        end
        332: checkOutput("ff.active_x3", int'(sif.slot_active[0]), 1);
        333: begin
          checkOutput("ff.x0_k333", xof(sif.slot_x, 0), 1);
          checkOutput("ff.active_x1", int'(sif.slot_active[0]), 1);
        end
        334: checkOutput("ff.retired_k334", int'(sif.slot_active), 2);
        451: checkOutput("ff.no_pulse_k451", pulses, 1);
        452: begin
          checkOutput("ff.pulse_k452", pulses, 2);
          checkOutput("ff.reuse_active", int'(sif.slot_active), 3);
          checkOutput("ff.reuse_x0", xof(sif.slot_x, 0), 667);
          checkOutput("ff.x1_k452", xof(sif.slot_x, 1), 215);
        end
        default: ;
      endcase
    end

    // GAP_MIN=4 instance: all slots busy, spawn deferred to the first retire
    doRestart(8'h00);
    pulses_g = 0;
    for (int t = 1; t <= 336; t++) begin
      doTick();
      case (t)
        6: begin
          checkOutput("defer.full_active", int'(gif.slot_active), 7);
          checkOutput("defer.three_spawns", pulses_g, 3);
        end
        335: begin
          checkOutput("defer.held_no_spawn", pulses_g, 3);
          checkOutput("defer.x0_t335", xof(gif.slot_x, 0), 1);
        end
        336: begin
          checkOutput("defer.spawn_on_retire", pulses_g, 4);
          checkOutput("defer.reuse_x0", xof(gif.slot_x, 0), 667);
          checkOutput("defer.active_t336", int'(gif.slot_active), 7);
          checkOutput("defer.x1_t336", xof(gif.slot_x, 1), 3);
        end
        default: ;
      endcase
    end

    // speed after many spawns
    doRestart(8'hFF);
    pulses = 0;
    for (int n = 0; n < 10000 && pulses < 32; n++) doTick();
    checkOutput("speed.reached_32", int'(pulses >= 32), 1);
`ifdef SCHED_SPEEDUP_EN
    checkOutput("speed.after_32", int'(sif.speed), 4);
    for (int n = 0; n < 30000 && pulses < 96; n++) doTick();
    checkOutput("speed.reached_96", int'(pulses >= 96), 1);
    checkOutput("speed.after_96", int'(sif.speed), 8);
    for (int n = 0; n < 10000 && pulses < 116; n++) doTick();
    checkOutput("speed.saturated", int'(sif.speed), 8);
`else
    checkOutput("speed.after_32", int'(sif.speed), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
